// File: rtl/clock_reset_sequencer.sv
// Runtime-programmable clock divider with a clock-enable strobe. It also
// releases NUM_RESETS reset domains one after another, timed in divided-clock periods.
module clock_reset_sequencer #(
  parameter int DIV_WIDTH      = 16,
  parameter int DEFAULT_DIV    = 2,
  parameter int RESET_CYCLES   = 20,
  parameter int NUM_RESETS     = 2,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic                  div_load_i,
  input  logic                  reset_req_i,
  output logic                  clk_o,
  output logic                  clk_en_o,
  output logic [NUM_RESETS-1:0] reset_o,
  output logic                  ready_o,
  output logic [DIV_WIDTH-1:0]  cur_div_o
);

  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] DIV_RST = (DEFAULT_DIV < 2) ? DIV_MIN : DIV_WIDTH'(DEFAULT_DIV);
  localparam int PCNT_MAX = (RESET_CYCLES > STAGGER_CYCLES) ? RESET_CYCLES : STAGGER_CYCLES;
  localparam int PCNT_W   = $clog2(PCNT_MAX + 1);
  localparam logic [PCNT_W-1:0] RC_LAST = PCNT_W'(RESET_CYCLES - 1);
  localparam logic [PCNT_W-1:0] SC_LAST = PCNT_W'(STAGGER_CYCLES - 1);

  typedef enum logic [1:0] {HOLD, COUNT, STAGGER, DONE} seq_state_t;

  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

  function automatic logic [PCNT_W-1:0] sat_inc(input logic [PCNT_W-1:0] v);
    return (v == {PCNT_W{1'b1}}) ? v : v + PCNT_W'(1);
  endfunction

  logic [DIV_WIDTH-1:0]  div_active;
  logic [DIV_WIDTH-1:0]  div_pending;
  logic [DIV_WIDTH-1:0]  cnt;
  logic [DIV_WIDTH-1:0]  cnt_next;
  logic                  wrap;
  seq_state_t            state;
  logic [PCNT_W-1:0]     pcnt;
  logic [NUM_RESETS-1:0] rel_next;

  // Counter parks at N-1 in reset, so the first edge starts a fresh period.
  assign wrap      = (cnt >= div_active - DIV_WIDTH'(1));
  assign cnt_next  = wrap ? '0 : cnt + DIV_WIDTH'(1);
  assign cur_div_o = div_active;
  assign rel_next  = reset_o << 1;

  // Divider stage: the active divisor changes only at a period boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= DIV_RST - DIV_WIDTH'(1);
      div_active  <= DIV_RST;
      div_pending <= DIV_RST;
      clk_o       <= 1'b0;
      clk_en_o    <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      clk_o    <= (cnt_next < (div_active >> 1));
      clk_en_o <= wrap;
      if (wrap)
        div_active <= div_pending;
      if (div_load_i)
        div_pending <= clamp_div(div_i);
    end
  end

  // Sequencer stage: the mask shifts left, so bit 0 is released first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= HOLD;
      pcnt    <= '0;
      reset_o <= '1;
      ready_o <= 1'b0;
    end else if (reset_req_i) begin
      state   <= HOLD;
      pcnt    <= '0;
      reset_o <= '1;
      ready_o <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          state <= COUNT;
          pcnt  <= '0;
        end
        COUNT: begin
          if (clk_en_o) begin
            if (pcnt >= RC_LAST) begin
              reset_o <= rel_next;
              pcnt    <= '0;
              if (rel_next == '0) begin
                ready_o <= 1'b1;
                state   <= DONE;
              end else begin
                state <= STAGGER;
              end
            end else begin
              pcnt <= sat_inc(pcnt);
            end
          end
        end
        STAGGER: begin
          if (clk_en_o) begin
            if (pcnt >= SC_LAST) begin
              reset_o <= rel_next;
              pcnt    <= '0;
              if (rel_next == '0) begin
                ready_o <= 1'b1;
                state   <= DONE;
              end
            end else begin
              pcnt <= sat_inc(pcnt);
            end
          end
        end
        DONE: begin
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Directed scoreboard bench for clock_reset_sequencer: divider ratios, divisor
// switching, staggered release, software re-sequence and async reset.
module tb_clock_reset_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic [15:0] div_i;
  logic div_load_i;
  logic reset_req_i;
  logic [15:0] zero_div = 16'd0;
  logic zero_bit = 1'b0;

  logic c_o, en_o, rdy_o;
  logic [1:0] r_o;
  logic [15:0] div_o;
  logic c3, en3, rdy3;
  logic [1:0] r3;
  logic [15:0] div3;
  logic c0, en0, rdy0;
  logic [1:0] r0;
  logic [15:0] div0;
  logic c1, en1, rdy1;
  logic [0:0] r1;
  logic [15:0] div1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int ph; int k;
    logic c; logic en; logic [1:0] r; logic rdy; logic [15:0] div;
    bit oth; logic c3; logic c0; logic en0; logic r1; logic rdy1;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  clock_reset_sequencer #(.DIV_WIDTH(16), .DEFAULT_DIV(4), .RESET_CYCLES(3), .NUM_RESETS(2), .STAGGER_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .div_i(div_i), .div_load_i(div_load_i), .reset_req_i(reset_req_i),
    .clk_o(c_o), .clk_en_o(en_o), .reset_o(r_o), .ready_o(rdy_o), .cur_div_o(div_o));

  clock_reset_sequencer #(.DIV_WIDTH(16), .DEFAULT_DIV(3), .RESET_CYCLES(3), .NUM_RESETS(2), .STAGGER_CYCLES(2)) dut3 (
    .clk(clk), .reset(reset), .div_i(zero_div), .div_load_i(zero_bit), .reset_req_i(zero_bit),
    .clk_o(c3), .clk_en_o(en3), .reset_o(r3), .ready_o(rdy3), .cur_div_o(div3));

  clock_reset_sequencer #(.DIV_WIDTH(16), .DEFAULT_DIV(0), .RESET_CYCLES(3), .NUM_RESETS(2), .STAGGER_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .div_i(zero_div), .div_load_i(zero_bit), .reset_req_i(zero_bit),
    .clk_o(c0), .clk_en_o(en0), .reset_o(r0), .ready_o(rdy0), .cur_div_o(div0));

  clock_reset_sequencer #(.DIV_WIDTH(16), .DEFAULT_DIV(4), .RESET_CYCLES(3), .NUM_RESETS(1), .STAGGER_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset), .div_i(zero_div), .div_load_i(zero_bit), .reset_req_i(zero_bit),
    .clk_o(c1), .clk_en_o(en1), .reset_o(r1), .ready_o(rdy1), .cur_div_o(div1));

  task automatic chk(input string nm, input int ph, input int k, input logic [31:0] obs, input logic [31:0] ex);
    checks++;
    assert (obs === ex) else begin
      failures++;
      $error("FAIL %s ph%0d edge%0d observed=%0h expected=%0h", nm, ph, k, obs, ex);
    end
  endtask

  task automatic reset_check(input int ph);
    chk("rst_clk_o", ph, 0, 32'(c_o), 32'd0);
    chk("rst_clk_en", ph, 0, 32'(en_o), 32'd0);
    chk("rst_reset_o", ph, 0, 32'(r_o), 32'd3);
    chk("rst_ready", ph, 0, 32'(rdy_o), 32'd0);
    chk("rst_cur_div", ph, 0, 32'(div_o), 32'd4);
    chk("rst_div3", ph, 0, 32'(div3), 32'd3);
    chk("rst_div0", ph, 0, 32'(div0), 32'd2);
    chk("rst_misc3", ph, 0, {28'd0, c3, en3, rdy3, 1'b0}, 32'd0);
    chk("rst_r3r0", ph, 0, {28'd0, r3, r0}, 32'hf);
    chk("rst_misc0", ph, 0, {29'd0, c0, en0, rdy0}, 32'd0);
    chk("rst_n1", ph, 0, {27'd0, c1, en1, rdy1, r1, 1'b0}, 32'd2);
    chk("rst_div1", ph, 0, 32'(div1), 32'd4);
  endtask

  // Push the expectation for the coming edge, then pop it once the edge has happened.
  task automatic step(input exp_t e);
    exp_t x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("clk_o", x.ph, x.k, 32'(c_o), 32'(x.c));
    chk("clk_en_o", x.ph, x.k, 32'(en_o), 32'(x.en));
    chk("reset_o", x.ph, x.k, 32'(r_o), 32'(x.r));
    chk("ready_o", x.ph, x.k, 32'(rdy_o), 32'(x.rdy));
    chk("cur_div_o", x.ph, x.k, 32'(div_o), 32'(x.div));
    if (x.oth) begin
      chk("div3_clk", x.ph, x.k, 32'(c3), 32'(x.c3));
      chk("div0_clk", x.ph, x.k, 32'(c0), 32'(x.c0));
      chk("div0_en", x.ph, x.k, 32'(en0), 32'(x.en0));
      chk("div0_cur", x.ph, x.k, 32'(div0), 32'd2);
      chk("n1_reset", x.ph, x.k, 32'(r1), 32'(x.r1));
      chk("n1_ready", x.ph, x.k, 32'(rdy1), 32'(x.rdy1));
    end
  endtask

  // Edge k counted from reset release, divide-by-4 with documented release edges.
  function automatic exp_t exp_a(input int ph, input int k);
    exp_t e;
    e.ph = ph; e.k = k;
    e.c = ((k - 1) % 4) < 2;
    e.en = ((k - 1) % 4) == 0;
    e.r = (k >= 18) ? 2'b00 : (k >= 10) ? 2'b10 : 2'b11;
    e.rdy = (k >= 18);
    e.div = 16'd4;
    e.oth = 1'b1;
    e.c3 = ((k - 1) % 3) == 0;
    e.c0 = (k % 2) == 1;
    e.en0 = (k % 2) == 1;
    e.r1 = (k < 10);
    e.rdy1 = (k >= 10);
    return e;
  endfunction

  // Divide-by-6 running with a period boundary on edge 37.
  function automatic exp_t exp_n6(input int ph, input int k, input logic [1:0] r, input logic rdy);
    exp_t e;
    int m;
    m = (k - 37) % 6;
    e.ph = ph; e.k = k;
    e.c = (m < 3);
    e.en = (m == 0);
    e.r = r;
    e.rdy = rdy;
    e.div = 16'd6;
    e.oth = 1'b0;
    e.c3 = 1'b0; e.c0 = 1'b0; e.en0 = 1'b0; e.r1 = 1'b0; e.rdy1 = 1'b0;
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [0:15] cb;
    bit [0:15] eb;
    exp_t e;
    reset = 1'b0; div_i = 16'd0; div_load_i = 1'b0; reset_req_i = 1'b0;
    #1 reset = 1'b1;
    #1 reset_check(0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int k = 1; k <= 20; k++) step(exp_a(1, k));

    // Switch 4 -> 6 with a load strobe while cnt==1.
    cb = 16'b1100111000111000;
    eb = 16'b1000100000100000;
    for (int i = 0; i < 16; i++) begin
      e = exp_n6(2, 21 + i, 2'b00, 1'b1);
      e.c = cb[i];
      e.en = eb[i];
      e.div = (i < 4) ? 16'd4 : 16'd6;
      step(e);
      if (i == 1) begin
        div_i = 16'd6;
        div_load_i = 1'b1;
      end else if (i == 2) begin
        div_load_i = 1'b0;
      end
    end

    reset_req_i = 1'b1;
    for (int k = 37; k <= 76; k++) begin
      step(exp_n6(3, k, (k < 62) ? 2'b11 : (k < 74) ? 2'b10 : 2'b00, (k >= 74)));
      if (k == 46) reset_req_i = 1'b0;
    end

    reset_req_i = 1'b1;
    for (int k = 77; k <= 94; k++) begin
      step(exp_n6(4, k, (k < 92) ? 2'b11 : 2'b10, 1'b0));
      if (k == 77) reset_req_i = 1'b0;
    end

    // Async reset mid-stagger, away from any clock edge.
    #2 reset = 1'b1;
    #1 reset_check(5);
    @(posedge clk);
    #1 reset_check(6);
    reset = 1'b0;

    for (int k = 1; k <= 20; k++) step(exp_a(7, k));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
